// File: rtl/pll_reset_seq_pkg.sv
// Shared types for the PLL reset sequencer: FSM states and counter width.
// Optional feature macro: PLL_RESET_SEQ_LOSS_COUNT_EN (see pll_reset_seq.sv).
package pll_reset_pkg;

    localparam int unsigned CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABILIZE,
        SYS_UP,
        RUN
    } state_e;

endpackage

// File: rtl/pll_reset_seq_if.sv
// Handshake bundle between the sequencer wrapper and its core.
// PLL_RESET_SEQ_LOSS_COUNT_EN adds the loss_count field.
interface pll_reset_seq_if;

    logic pll_lock;
    logic soft_rst_req;
    logic sys_rst;
    logic periph_rst;
    logic ready;
    logic lock_lost;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_count;
`endif

    modport master (
        output pll_lock, soft_rst_req,
        input  sys_rst, periph_rst, ready, lock_lost
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
        , input loss_count
`endif
    );

    modport slave (
        input  pll_lock, soft_rst_req,
        output sys_rst, periph_rst, ready, lock_lost
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
        , output loss_count
`endif
    );

endinterface

// File: rtl/pll_reset_seq_core.sv
// Reset sequencing FSM: lock stabilisation, core release, delayed peripheral release.
// PLL_RESET_SEQ_LOSS_COUNT_EN enables the saturating RUN-lock-loss counter.
module pll_reset_seq_core
    import pll_reset_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned PERIPH_DELAY_CYCLES = 16
) (
    input logic clk,
    input logic rst,
    pll_reset_seq_if.slave bus
);

    localparam cnt_t STAB_LAST   = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam cnt_t PERIPH_LAST = cnt_t'(PERIPH_DELAY_CYCLES - 1);

    state_e state_q;
    cnt_t   cnt_q;
    cnt_t   cnt_d;
    logic   lock_s;
    logic   sys_rst_q;
    logic   periph_rst_q;
    logic   ready_q;
    logic   lock_lost_q;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_q;
`endif

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.pll_lock),
        .q_o (lock_s)
    );

    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Priority: rst, then lock loss, then soft request, then normal progression.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            sys_rst_q    <= 1'b1;
            periph_rst_q <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
            loss_q       <= '0;
`endif
        end else if (!lock_s && state_q != WAIT_LOCK) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            sys_rst_q    <= 1'b1;
            periph_rst_q <= 1'b1;
            ready_q      <= 1'b0;
            if (state_q == RUN) begin
                lock_lost_q <= 1'b1;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
                if (loss_q != '1) loss_q <= loss_q + 1'b1;
`endif
            end
        end else if (bus.soft_rst_req && (state_q == SYS_UP || state_q == RUN)) begin
            state_q      <= STABILIZE;
            cnt_q        <= '0;
            sys_rst_q    <= 1'b1;
            periph_rst_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cnt_q <= '0;
                    if (lock_s) state_q <= STABILIZE;
                end
                STABILIZE: begin
                    if (cnt_q == STAB_LAST) begin
                        state_q   <= SYS_UP;
                        cnt_q     <= '0;
                        sys_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                SYS_UP: begin
                    if (cnt_q == PERIPH_LAST) begin
                        state_q      <= RUN;
                        cnt_q        <= '0;
                        periph_rst_q <= 1'b0;
                        ready_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RUN: ;
                default: state_q <= WAIT_LOCK;
            endcase
        end
    end

    assign bus.sys_rst    = sys_rst_q;
    assign bus.periph_rst = periph_rst_q;
    assign bus.ready      = ready_q;
    assign bus.lock_lost  = lock_lost_q;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    assign bus.loss_count = loss_q;
`endif

endmodule

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock-driven reset sequencer top with flat ports.
// Define PLL_RESET_SEQ_LOSS_COUNT_EN to add the loss_count[7:0] output.
module pll_reset_seq #(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned PERIPH_DELAY_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       soft_rst_req,
    output logic       sys_rst,
    output logic       periph_rst,
    output logic       ready,
    output logic       lock_lost
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    , output logic [7:0] loss_count
`endif
);

    pll_reset_seq_if bus ();

    assign bus.pll_lock     = pll_lock;
    assign bus.soft_rst_req = soft_rst_req;
    assign sys_rst          = bus.sys_rst;
    assign periph_rst       = bus.periph_rst;
    assign ready            = bus.ready;
    assign lock_lost        = bus.lock_lost;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    assign loss_count       = bus.loss_count;
`endif

    pll_reset_seq_core #(
        .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
        .PERIPH_DELAY_CYCLES (PERIPH_DELAY_CYCLES)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: directed scenarios plus randomized lock/soft/rst traffic.
// Honours PLL_RESET_SEQ_LOSS_COUNT_EN for the loss_count output.
module tb_pll_reset_seq;

    localparam int L = 8;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst;

    pll_reset_seq_if tb_bus ();

    always #5 clk = ~clk;

    pll_reset_seq #(
        .LOCK_STABLE_CYCLES  (L),
        .PERIPH_DELAY_CYCLES (P)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (tb_bus.pll_lock),
        .soft_rst_req (tb_bus.soft_rst_req),
        .sys_rst      (tb_bus.sys_rst),
        .periph_rst   (tb_bus.periph_rst),
        .ready        (tb_bus.ready),
        .lock_lost    (tb_bus.lock_lost)
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
        , .loss_count (tb_bus.loss_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: after leaving WAIT_LOCK at edge m_start, outputs are a pure
    // function of the age (edges since m_start); lock_s is pll_lock two edges ago.
    bit hist[$] = '{1'b0, 1'b0, 1'b0};
    bit m_wait  = 1'b1;
    bit m_lost  = 1'b0;
    int m_start = 0;
    int m_lc    = 0;
    bit m_sys   = 1'b1;
    bit m_per   = 1'b1;
    bit m_rdy   = 1'b0;
    bit model_ok = 1'b0;

    always @(posedge clk) begin
        bit ls;
        int pa;
        int age;
        cyc++;
        if (rst) begin
            hist     = '{1'b0, 1'b0, 1'b0};
            m_wait   = 1'b1;
            m_lost   = 1'b0;
            m_lc     = 0;
            model_ok = 1'b1;
        end else begin
            hist.push_back(tb_bus.pll_lock);
            void'(hist.pop_front());
            ls = hist[0];
            if (m_wait) begin
                if (ls) begin
                    m_wait  = 1'b0;
                    m_start = cyc;
                end
            end else begin
                pa = cyc - 1 - m_start;
                if (!ls) begin
                    m_wait = 1'b1;
                    if (pa >= L + P) begin
                        m_lost = 1'b1;
                        if (m_lc < 255) m_lc++;
                    end
                end else if (tb_bus.soft_rst_req && pa >= L) begin
                    m_start = cyc;
                end
            end
        end
        if (m_wait) begin
            m_sys = 1'b1;
            m_per = 1'b1;
        end else begin
            age   = cyc - m_start;
            m_sys = (age < L);
            m_per = (age < L + P);
        end
        m_rdy = !m_per;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_sys_rst",    8'(tb_bus.sys_rst),    8'(m_sys));
            chk("model_periph_rst", 8'(tb_bus.periph_rst), 8'(m_per));
            chk("model_ready",      8'(tb_bus.ready),      8'(m_rdy));
            chk("model_lock_lost",  8'(tb_bus.lock_lost),  8'(m_lost));
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
            chk("model_loss_count", tb_bus.loss_count,     8'(m_lc));
`endif
        end
    end

    task automatic at_edge(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        int t0;
        int e;
        int s;
        rst = 1'b1;
        tb_bus.pll_lock     = 1'b0;
        tb_bus.soft_rst_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_sys_rst",    8'(tb_bus.sys_rst),    8'd1);
        chk("reset_periph_rst", 8'(tb_bus.periph_rst), 8'd1);
        chk("reset_ready",      8'(tb_bus.ready),      8'd0);
        chk("reset_lock_lost",  8'(tb_bus.lock_lost),  8'd0);

        // Clean power-up: lock sampled high at edge t0.
        rst = 1'b0;
        tb_bus.pll_lock = 1'b1;
        t0 = cyc + 1;
        at_edge(t0 + 9);  chk("up_sys_before",  8'(tb_bus.sys_rst),    8'd1);
        at_edge(t0 + 10); chk("up_sys_fall",    8'(tb_bus.sys_rst),    8'd0);
                          chk("up_per_held",    8'(tb_bus.periph_rst), 8'd1);
        at_edge(t0 + 13); chk("up_rdy_before",  8'(tb_bus.ready),      8'd0);
        at_edge(t0 + 14); chk("up_per_fall",    8'(tb_bus.periph_rst), 8'd0);
                          chk("up_ready",       8'(tb_bus.ready),      8'd1);
                          chk("up_lost_clear",  8'(tb_bus.lock_lost),  8'd0);

        // Lock loss in RUN, then recovery.
        at_edge(t0 + 20);
        tb_bus.pll_lock = 1'b0;
        e = cyc + 1;
        at_edge(e + 1); chk("loss_still_ready", 8'(tb_bus.ready),      8'd1);
        at_edge(e + 2); chk("loss_sys",         8'(tb_bus.sys_rst),    8'd1);
                        chk("loss_per",         8'(tb_bus.periph_rst), 8'd1);
                        chk("loss_ready",       8'(tb_bus.ready),      8'd0);
                        chk("loss_lost",        8'(tb_bus.lock_lost),  8'd1);
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
                        chk("loss_count1",      tb_bus.loss_count,     8'd1);
`endif
        tb_bus.pll_lock = 1'b1;
        at_edge(e + 12); chk("relock_sys_before", 8'(tb_bus.sys_rst), 8'd1);
        at_edge(e + 13); chk("relock_sys_fall",   8'(tb_bus.sys_rst), 8'd0);
        at_edge(e + 17); chk("relock_ready",      8'(tb_bus.ready),   8'd1);
                         chk("relock_lost_kept",  8'(tb_bus.lock_lost), 8'd1);

        // Soft reset from RUN.
        at_edge(cyc + 3);
        tb_bus.soft_rst_req = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        tb_bus.soft_rst_req = 1'b0;
        chk("soft_sys",         8'(tb_bus.sys_rst),    8'd1);
        chk("soft_per",         8'(tb_bus.periph_rst), 8'd1);
        at_edge(s + 7);  chk("soft_sys_before", 8'(tb_bus.sys_rst),    8'd1);
        at_edge(s + 8);  chk("soft_sys_fall",   8'(tb_bus.sys_rst),    8'd0);
        at_edge(s + 11); chk("soft_per_before", 8'(tb_bus.periph_rst), 8'd1);
        at_edge(s + 12); chk("soft_per_fall",   8'(tb_bus.periph_rst), 8'd0);
                         chk("soft_lost_kept",  8'(tb_bus.lock_lost),  8'd1);

        // Soft request on the same edge that lock_s is seen low: lock loss wins.
        at_edge(cyc + 2);
        tb_bus.pll_lock = 1'b0;
        e = cyc + 1;
        @(negedge clk);
        tb_bus.pll_lock = 1'b1;
        at_edge(e + 1);
        tb_bus.soft_rst_req = 1'b1;
        @(negedge clk);
        tb_bus.soft_rst_req = 1'b0;
        chk("both_ready", 8'(tb_bus.ready), 8'd0);
        at_edge(e + 10); chk("both_sys_wait", 8'(tb_bus.sys_rst), 8'd1);
        at_edge(e + 11); chk("both_sys_fall", 8'(tb_bus.sys_rst), 8'd0);
        at_edge(e + 15); chk("both_ready_up", 8'(tb_bus.ready),   8'd1);

        // rst asserted during SYS_UP.
        tb_bus.soft_rst_req = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        tb_bus.soft_rst_req = 1'b0;
        at_edge(s + 9);
        chk("sysup_state", 8'(tb_bus.periph_rst), 8'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sys",   8'(tb_bus.sys_rst),    8'd1);
        chk("midrst_per",   8'(tb_bus.periph_rst), 8'd1);
        chk("midrst_ready", 8'(tb_bus.ready),      8'd0);
        chk("midrst_lost",  8'(tb_bus.lock_lost),  8'd0);
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
        chk("midrst_count", tb_bus.loss_count,     8'd0);
`endif
        rst = 1'b0;
        t0 = cyc + 1;
        at_edge(t0 + 9);  chk("rerun_sys_before", 8'(tb_bus.sys_rst), 8'd1);
        at_edge(t0 + 10); chk("rerun_sys_fall",   8'(tb_bus.sys_rst), 8'd0);

        // One-cycle lock glitch during STABILIZE restarts the count.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc + 1;
        at_edge(t0 + 5);
        tb_bus.pll_lock = 1'b0;
        @(negedge clk);
        tb_bus.pll_lock = 1'b1;
        at_edge(t0 + 10); chk("glitch_sys_held",   8'(tb_bus.sys_rst), 8'd1);
        at_edge(t0 + 16); chk("glitch_sys_before", 8'(tb_bus.sys_rst), 8'd1);
        at_edge(t0 + 17); chk("glitch_sys_fall",   8'(tb_bus.sys_rst), 8'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst                 = ($urandom_range(0, 399) == 0);
            tb_bus.pll_lock     = ($urandom_range(0, 99) != 0);
            tb_bus.soft_rst_req = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        tb_bus.soft_rst_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronised-lock cycles required before sys_rst releases; legal range 2..65535.
REQ-002 SHALL have parameter PERIPH_DELAY_CYCLES, default 16: cycles between sys_rst release and periph_rst release; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock, driven from the fabric CCC global GL0.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pll_lock, input, 1 bit: CCC LOCK, asynchronous to clk.
REQ-006 SHALL have port soft_rst_req, input, 1 bit: single-cycle software reset request.
REQ-007 SHALL have port sys_rst, output, 1 bit: active-high core reset.
REQ-008 SHALL have port periph_rst, output, 1 bit: active-high peripheral reset.
REQ-009 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-010 SHALL have port lock_lost, output, 1 bit: sticky flag, set when lock is lost while in RUN.

Function
REQ-011 SHALL synchronise pll_lock through 2 flip-flops to produce lock_s; no other logic SHALL use pll_lock directly.
REQ-012 SHALL implement the states WAIT_LOCK, STABILIZE, SYS_UP and RUN.
REQ-013 WAIT_LOCK: counter = 0 and sys_rst = periph_rst = 1; SHALL go to STABILIZE when lock_s = 1.
REQ-014 STABILIZE: counter increments each cycle; SHALL go to SYS_UP after LOCK_STABLE_CYCLES cycles in STABILIZE.
REQ-015 SYS_UP: sys_rst = 0 and periph_rst = 1; counter restarts at 0; SHALL go to RUN after PERIPH_DELAY_CYCLES cycles.
REQ-016 RUN: sys_rst = 0, periph_rst = 0, ready = 1.
REQ-017 All outputs SHALL be registered and SHALL change on the edge where the state changes.
REQ-018 Latency: with pll_lock first sampled high at edge 0, sys_rst SHALL fall at edge 2+LOCK_STABLE_CYCLES and periph_rst SHALL fall at edge 2+LOCK_STABLE_CYCLES+PERIPH_DELAY_CYCLES.
REQ-019 lock_s = 0 in any state other than WAIT_LOCK SHALL force WAIT_LOCK on the next edge and reassert both resets on that edge.
REQ-020 Lock loss while in RUN SHALL also set lock_lost; lock_lost SHALL clear only on rst.
REQ-021 soft_rst_req in SYS_UP or RUN SHALL reassert both resets and go to STABILIZE with counter = 0; soft_rst_req SHALL be ignored in WAIT_LOCK and STABILIZE.
REQ-022 If lock loss and soft_rst_req occur in the same cycle, lock loss SHALL win.
REQ-023 A lock glitch of 1 cycle in STABILIZE SHALL restart the stabilisation count from 0.
REQ-024 Counters SHALL be 16 bits, unsigned, and SHALL never wrap; comparisons SHALL use the parameter value minus 1.

Reset
REQ-025 While rst = 1, the block SHALL set state WAIT_LOCK, counter 0, sync flops 0, sys_rst = 1, periph_rst = 1, ready = 0, lock_lost = 0 and loss_count = 0.
REQ-026 rst asserted mid-sequence SHALL abort the sequence immediately; after rst releases, the full stabilisation SHALL repeat.

Configuration
REQ-027 With macro PLL_RESET_SEQ_LOSS_COUNT_EN defined, the block SHALL add output loss_count[7:0], which increments on each RUN-to-WAIT_LOCK transition, saturates at 255, and clears only on rst.
REQ-028 Without PLL_RESET_SEQ_LOSS_COUNT_EN, port loss_count SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 The state enumeration and the counter width constant (16) SHALL reside in the shared package pll_reset_pkg.
REQ-030 The 2-flop synchroniser SHALL be a separate sub-module named sync_2ff, which is reusable across the codebase.

Verification (bench parameters LOCK_STABLE_CYCLES = 8, PERIPH_DELAY_CYCLES = 4)
REQ-031 Release rst, then hold pll_lock = 1 from edge 0 -> sys_rst falls at edge 10, periph_rst and ready change at edge 14, lock_lost = 0.
REQ-032 Drop pll_lock for 1 cycle at edge 6 -> sys_rst stays 1; release occurs 8 STABILIZE cycles after lock_s returns.
REQ-033 In RUN, drop pll_lock -> 3 edges later both resets = 1, ready = 0, lock_lost = 1 (and loss_count = 1 when the macro is enabled); restoring lock repeats the full sequence while lock_lost stays 1.
REQ-034 Pulse soft_rst_req in RUN -> resets assert on the next edge; sys_rst releases after 8 cycles and periph_rst 4 cycles later; lock_lost is unchanged.
REQ-035 Apply soft_rst_req in the same cycle as lock_s falls -> state becomes WAIT_LOCK, not STABILIZE.
REQ-036 Assert rst during SYS_UP -> next edge shows all outputs at reset values, and lock_lost and loss_count return to 0.
